// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: UART receiver with parity/framing/break checks feeding a ready/valid FIFO
module uart_rx_monitor #(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_break,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          busy
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int EW = DATA_BITS + 3;
    localparam logic [CW-1:0] MID = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);
    localparam logic HAS_PAR = PARITY != 0;
    localparam logic ODD = PARITY == 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t state_q, state_d;
    logic rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic par_q, par_d, ferr_q, ferr_d;
    logic mid, push, pop, acc;
    logic [EW-1:0] entry, head_d, head_q;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic valid_q, valid_d, overflow_q, overflow_d;

    assign mid = cnt_q == MID;

    // The bit counter free-runs modulo BAUD_DIV from the start edge, so every later sample lands mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        bit_d = bit_q;
        shreg_d = shreg_q;
        par_d = par_q;
        ferr_d = ferr_q;
        push = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                par_d = 1'b0;
                ferr_d = 1'b0;
                state_d = rx_s_q ? IDLE : START;
            end
            START: state_d = !mid ? START : (rx_s_q ? IDLE : DATA);
            DATA: if (mid) begin
                shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                bit_d = (bit_q == 4'(DATA_BITS - 1)) ? '0 : bit_q + 4'd1;
                state_d = (bit_q != 4'(DATA_BITS - 1)) ? DATA : (HAS_PAR ? PAR : STOP);
            end
            PAR: if (mid) begin
                par_d = rx_s_q;
                state_d = STOP;
            end
            STOP: if (mid) begin
                ferr_d = ferr_q | ~rx_s_q;
                bit_d = bit_q + 4'd1;
                push = bit_q == 4'(STOP_BITS - 1);
                state_d = !push ? STOP : (rx_s_q ? IDLE : WAIT_HI);
            end
            WAIT_HI: state_d = rx_s_q ? IDLE : WAIT_HI;
            default: state_d = IDLE;
        endcase
    end

    assign entry = {ferr_d & ~|shreg_q & (~HAS_PAR | ~par_q), ferr_d,
                    HAS_PAR & ((^shreg_q ^ par_q) != ODD), shreg_q};

    assign pop = valid_q & rd_ready;
    assign acc = push & (count_q != FULL | pop);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    assign wr_ptr_d = wr_ptr_q + AW'(acc);
    assign count_d = count_q + NW'(acc) - NW'(pop);
    assign valid_d = count_d != '0;
    // The head is registered; a frame landing in an empty FIFO bypasses the memory.
    assign head_d = !valid_d ? '0 : (acc && wr_ptr_q == rd_ptr_d) ? entry : mem[rd_ptr_d];
    assign overflow_d = (push & ~acc) | (overflow_q & ~clr_overflow);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shreg_q <= '0;
            par_q <= 1'b0;
            ferr_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q <= rx_meta_q;
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shreg_q <= shreg_d;
            par_q <= par_d;
            ferr_q <= ferr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            head_q <= head_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem[wr_ptr_q] <= entry;
    end

    assign {rd_break, rd_ferr, rd_perr, rd_data} = head_q;
    assign rd_valid = valid_q;
    assign fifo_count = count_q;
    assign overflow = overflow_q;
    assign busy = state_q != IDLE;
endmodule
